// File: rtl/stopwatch_time_sender.sv
// Serialises a latched stopwatch time as an ASCII "HH:MM:SS.CC" frame (optionally CR LF)
// towards a UART transmitter using a valid/ready byte handshake.
module stopwatch_time_sender #(
    parameter int unsigned SEND_CRLF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_send,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy
);

    typedef enum logic {StIdle, StSend} state_e;

    localparam logic [3:0] LastIdx = (SEND_CRLF != 0) ? 4'd12 : 4'd10;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] msec_q, msec_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;

    logic [4:0] sat_hour;
    logic [5:0] sat_min, sat_sec;
    logic [6:0] sat_msec;

    assign sat_hour = (i_hour > 5'd23) ? 5'd23 : i_hour;
    assign sat_min  = (i_min > 6'd59) ? 6'd59 : i_min;
    assign sat_sec  = (i_sec > 6'd59) ? 6'd59 : i_sec;
    assign sat_msec = (i_msec > 7'd99) ? 7'd99 : i_msec;

    function automatic logic [7:0] ascii_digit(logic [6:0] v, logic tens);
        logic [6:0] d;
        d = tens ? (v / 7'd10) : (v % 7'd10);
        return 8'h30 + {1'b0, d};
    endfunction

    function automatic logic [7:0] frame_byte(logic [3:0] idx, logic [4:0] h, logic [5:0] m,
                                              logic [5:0] s, logic [6:0] c);
        logic [7:0] b;
        case (idx)
            4'd0:          b = ascii_digit({2'b00, h}, 1'b1);
            4'd1:          b = ascii_digit({2'b00, h}, 1'b0);
            4'd3:          b = ascii_digit({1'b0, m}, 1'b1);
            4'd4:          b = ascii_digit({1'b0, m}, 1'b0);
            4'd2, 4'd5:    b = 8'h3A;
            4'd6:          b = ascii_digit({1'b0, s}, 1'b1);
            4'd7:          b = ascii_digit({1'b0, s}, 1'b0);
            4'd8:          b = 8'h2E;
            4'd9:          b = ascii_digit(c, 1'b1);
            4'd10:         b = ascii_digit(c, 1'b0);
            4'd11:         b = 8'h0D;
            4'd12:         b = 8'h0A;
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        msec_d     = msec_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        case (state_q)
            StIdle: begin
                if (i_send) begin
                    state_d    = StSend;
                    idx_d      = 4'd0;
                    hour_d     = sat_hour;
                    min_d      = sat_min;
                    sec_d      = sat_sec;
                    msec_d     = sat_msec;
                    // First byte comes straight from the inputs being latched this edge.
                    tx_data_d  = frame_byte(4'd0, sat_hour, sat_min, sat_sec, sat_msec);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            StSend: begin
                if (tx_valid_q && i_tx_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d    = StIdle;
                        idx_d      = 4'd0;
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = frame_byte(idx_q + 4'd1, hour_q, min_q, sec_q, msec_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            msec_q     <= 7'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            msec_q     <= msec_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_stopwatch_time_sender.sv
// Bench for stopwatch_time_sender: frame table, hand-written corner sequences and random
// frames checked against a string-formatting reference model.
module tb_stopwatch_time_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send0 = 1'b0;
    logic       send1 = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic       tx_ready = 1'b1;
    logic [7:0] d0_data, d1_data;
    logic       d0_valid, d1_valid, d0_busy, d1_busy;

    int sel = 0;
    logic [7:0] cur_data;
    logic       cur_valid, cur_busy;
    assign cur_data  = (sel != 0) ? d1_data : d0_data;
    assign cur_valid = (sel != 0) ? d1_valid : d0_valid;
    assign cur_busy  = (sel != 0) ? d1_busy : d0_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    stopwatch_time_sender #(.SEND_CRLF(1)) u_dut_crlf (
        .clk(clk), .rst(rst), .i_send(send0), .i_msec(msec), .i_sec(sec), .i_min(min),
        .i_hour(hour), .o_tx_data(d0_data), .o_tx_valid(d0_valid), .i_tx_ready(tx_ready),
        .o_busy(d0_busy)
    );

    stopwatch_time_sender #(.SEND_CRLF(0)) u_dut_nocrlf (
        .clk(clk), .rst(rst), .i_send(send1), .i_msec(msec), .i_sec(sec), .i_min(min),
        .i_hour(hour), .o_tx_data(d1_data), .o_tx_valid(d1_valid), .i_tx_ready(tx_ready),
        .o_busy(d1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the frame is just the saturated time printed with two digits per field.
    function automatic string model(int h, int m, int s, int c, int crlf);
        string f;
        f = $sformatf("%02d:%02d:%02d.%02d", (h > 23) ? 23 : h, (m > 59) ? 59 : m,
                      (s > 59) ? 59 : s, (c > 99) ? 99 : c);
        if (crlf != 0) f = {f, "\015\012"};
        return f;
    endfunction

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
        msec = 7'(c);
    endtask

    task automatic compare_frame(input string name, input string exp);
        int n;
        check({name, "_len"}, got_q.size(), exp.len());
        n = (got_q.size() < exp.len()) ? got_q.size() : exp.len();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'h0, got_q[i]}, {24'h0, exp[i]});
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({name, "_idle_valid"}, {31'h0, cur_valid}, 0);
            check({name, "_idle_busy"}, {31'h0, cur_busy}, 0);
            check({name, "_idle_data"}, {24'h0, cur_data}, 0);
        end
    endtask

    // Called #1 after a rising edge. Index values of -1 disable the corresponding action.
    task automatic run_frame(input int s, input int stall_pct, input int stall_idx,
                             input int disturb_at, input int reset_at, output int cycles);
        int idx, held, budget;
        logic [7:0] d;
        sel = s;
        got_q.delete();
        idx = 0; held = 0; cycles = 0; budget = 0;
        if (s == 0) send0 = 1'b1; else send1 = 1'b1;
        @(posedge clk); #1;
        send0 = 1'b0; send1 = 1'b0;
        check("latency_valid", {31'h0, cur_valid}, 1);
        check("latency_busy", {31'h0, cur_busy}, 1);
        while (cur_valid === 1'b1 && budget < 400) begin
            budget++;
            cycles++;
            if (idx == reset_at) begin
                #2 rst = 1'b0;
                #1;
                check("abort_valid", {31'h0, cur_valid}, 0);
                check("abort_busy", {31'h0, cur_busy}, 0);
                check("abort_data", {24'h0, cur_data}, 0);
                @(posedge clk); #3 rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (idx == disturb_at) begin
                set_time(23, 59, 59, 99);
                if (s == 0) send0 = 1'b1; else send1 = 1'b1;
            end
            tx_ready = ($urandom_range(99) >= stall_pct);
            if (idx == stall_idx && held < 5) tx_ready = 1'b0;
            d = cur_data;
            @(posedge clk); #1;
            send0 = 1'b0; send1 = 1'b0;
            if (tx_ready) begin
                got_q.push_back(d);
                idx++;
            end else begin
                held++;
                check("stall_data", {24'h0, cur_data}, {24'h0, d});
                check("stall_valid", {31'h0, cur_valid}, 1);
            end
        end
        tx_ready = 1'b1;
        if (budget >= 400) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got still valid after %0d cycles expected end", budget);
        end
        check("end_busy", {31'h0, cur_busy}, 0);
        check("end_data", {24'h0, cur_data}, 0);
    endtask

    typedef struct {
        int    h, m, s, c;
        int    sel;
        int    stall;
        string exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, h, m, s, c, sl, st;
        vecs[0] = '{13, 5, 42, 7, 0, 0, "13:05:42.07\015\012"};
        vecs[1] = '{0, 0, 0, 0, 0, 30, "00:00:00.00\015\012"};
        vecs[2] = '{23, 59, 59, 99, 0, 0, "23:59:59.99\015\012"};
        vecs[3] = '{30, 5, 7, 120, 1, 0, "23:05:07.99"};
        vecs[4] = '{31, 63, 63, 127, 0, 50, "23:59:59.99\015\012"};
        vecs[5] = '{9, 10, 11, 12, 1, 20, "09:10:11.12"};

        // Asynchronous reset seen before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("reset_valid", {31'h0, d0_valid}, 0);
        check("reset_busy", {31'h0, d0_busy}, 0);
        check("reset_data", {24'h0, d0_data}, 0);
        check("reset_valid_nocrlf", {31'h0, d1_valid}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            set_time(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].c);
            run_frame(vecs[i].sel, vecs[i].stall, -1, -1, -1, cyc);
            compare_frame($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].stall == 0) check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp.len());
            idle_check($sformatf("vec%0d", i), 3);
        end

        set_time(13, 5, 42, 7);
        run_frame(0, 0, 3, -1, -1, cyc);
        compare_frame("stall_idx3", "13:05:42.07\015\012");
        check("stall_idx3_cycles", cyc, 18);

        set_time(13, 5, 42, 7);
        run_frame(0, 0, -1, 4, -1, cyc);
        compare_frame("snapshot", "13:05:42.07\015\012");
        idle_check("no_queue", 10);

        set_time(13, 5, 42, 7);
        run_frame(0, 0, -1, 12, -1, cyc);
        compare_frame("send_on_last", "13:05:42.07\015\012");
        idle_check("send_on_last", 10);

        set_time(13, 5, 42, 7);
        run_frame(1, 0, -1, 10, -1, cyc);
        compare_frame("send_on_last_nocrlf", "13:05:42.07");
        idle_check("send_on_last_nocrlf", 5);

        set_time(13, 5, 42, 7);
        run_frame(0, 0, -1, -1, 6, cyc);
        idle_check("after_abort", 10);
        run_frame(0, 0, -1, -1, -1, cyc);
        compare_frame("after_abort_frame", "13:05:42.07\015\012");

        for (int k = 0; k < 20; k++) begin
            h = $urandom_range(31);
            m = $urandom_range(63);
            s = $urandom_range(63);
            c = $urandom_range(127);
            sl = $urandom_range(1);
            st = $urandom_range(60);
            set_time(h, m, s, c);
            run_frame(sl, st, -1, -1, -1, cyc);
            compare_frame($sformatf("rand%0d", k), model(h, m, s, c, (sl == 0) ? 1 : 0));
            idle_check($sformatf("rand%0d", k), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_sender.md
STOPWATCH_TIME_SENDER -- requirements
Module: stopwatch_time_sender

Interface
REQ-001 Parameter SEND_CRLF, default 1, meaning: 1 appends CR LF to each frame, 0 omits them.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 i_send  input  1  frame request, sampled each rising edge.
REQ-005 i_msec  input  7  centiseconds from the stopwatch/watch datapath, legal range 0..99.
REQ-006 i_sec  input  6  seconds, legal range 0..59.
REQ-007 i_min  input  6  minutes, legal range 0..59.
REQ-008 i_hour  input  5  hours, legal range 0..23.
REQ-009 o_tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-010 o_tx_valid  output  1  o_tx_data is valid.
REQ-011 i_tx_ready  input  1  the UART transmitter accepts a byte this cycle.
REQ-012 o_busy  output  1  a frame is in progress.

Function
REQ-013 The frame SHALL be "HH:MM:SS.CC" followed by 0x0D 0x0A when SEND_CRLF=1, for 13 bytes, or 11 bytes when SEND_CRLF=0.
REQ-014 Each field SHALL be two decimal digits with a leading zero.
- Tens digit = value/10.
- Units digit = value%10.
- Byte = 0x30 + digit.
- Separators: ':' = 0x3A, '.' = 0x2E.
REQ-015 An out-of-range input SHALL saturate to its field maximum before conversion: msec to 99, sec and min to 59, hour to 23.
REQ-016 The FSM SHALL have two states, IDLE and SEND, plus a byte index of 0..12.
REQ-017 In IDLE with i_send=1, the FSM SHALL do the following on that edge:
- Latch i_hour, i_min, i_sec and i_msec into snapshot registers.
- Set the byte index to 0.
- Enter SEND.
REQ-018 o_tx_valid=1 and o_busy=1 SHALL be visible from the cycle after i_send is sampled, giving a latency of one clock.
REQ-019 A transfer SHALL occur on an edge where o_tx_valid=1 and i_tx_ready=1 are both true.
REQ-020 On a non-final transfer, the index SHALL increment and the next byte SHALL be presented in the following cycle with o_tx_valid kept at 1.
- With i_tx_ready held at 1, a frame takes 13 (or 11) consecutive cycles.
REQ-021 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid SHALL hold stable.
REQ-022 On the transfer of the final byte, the FSM SHALL return to IDLE, and o_tx_valid and o_busy SHALL be 0 in the next cycle.
REQ-023 i_send asserted while in SEND SHALL be ignored and not queued.
REQ-024 i_send sampled in the same cycle the FSM returns to IDLE SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 Frame content SHALL come only from the snapshot; input changes after latching SHALL NOT affect the current frame.
REQ-026 In IDLE, o_tx_valid SHALL be 0 and o_tx_data SHALL be 0x00.
REQ-027 All outputs SHALL be registered, with no combinational path from i_tx_ready to o_tx_valid.

Reset
REQ-028 While rst=0, the block SHALL force the following immediately, independent of clk:
- State = IDLE and index = 0.
- Snapshot registers = 0.
- o_tx_data = 0x00, o_tx_valid = 0, o_busy = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after rst returns to 1, the block SHALL stay in IDLE and SHALL NOT resume.

Verification
REQ-030 The bench SHALL cover each of the following scenarios:
- rst=0 at arbitrary time -> o_tx_valid=0, o_busy=0, o_tx_data=0x00 without waiting for a clock edge.
- hour=13, min=5, sec=42, msec=7, one-cycle i_send, i_tx_ready=1 -> bytes 31 33 3A 30 35 3A 34 32 2E 30 37 0D 0A on 13 consecutive cycles, o_busy=0 on cycle 14.
- Same frame with i_tx_ready=0 for 5 cycles while byte index 3 (0x30) is offered -> o_tx_data=0x30 and o_tx_valid=1 stable throughout, then the sequence continues intact.
- Inputs changed to 23:59:59.99 and i_send pulsed again during a frame -> frame still reads 13:05:42.07 and no second frame follows.
- rst pulsed low while byte index 6 is offered -> outputs cleared, and no bytes appear after release until a new i_send.
- msec=120, hour=30, SEND_CRLF=0 -> "23:MM:SS.99" as exactly 11 bytes, then idle.
